// File: rtl/evm_pkg.sv
// Shared voting-machine types and defaults.
// Used by the ballot controller, counter bank and display.
package evm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    CAST,
    LOCK,
    RESULT
  } state_t;

  localparam int N_CAND_DEF = 4;
  localparam int CNT_W_DEF  = 10;
  localparam int LOCK_DEF   = 8;

  function automatic logic [3:0] popcnt8(
    input logic [7:0] v
  );
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/btn_edge_detect.sv
// Registered rising-edge detector for the candidate buttons.
// A button held across edges yields one event only.
module btn_edge_detect #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] btn,
  output logic [W-1:0] rise
);

  logic [W-1:0] btn_q;

  // Keep last cycle's button levels.
  always_ff @(posedge clk) begin
    if (!resetn) btn_q <= '0;
    else         btn_q <= btn;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/vote_controller.sv
// Ballot sequencer: arm, accept one press, pulse the
// counter, lock out; result mode muxes and clears counts.
module vote_controller
  import evm_pkg::*;
#(
  parameter int N_CAND      = N_CAND_DEF,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int LOCK_CYCLES = LOCK_DEF
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      ballot_en,
  input  logic [N_CAND-1:0]         cand_btn,
  input  logic                      mode_result,
  input  logic [$clog2(N_CAND)-1:0] result_sel,
  input  logic                      clear_req,
  input  logic [N_CAND*CNT_W-1:0]   count_val,
  output logic [N_CAND-1:0]         count_inc,
  output logic                      counter_clr,
  output logic                      ready_led,
  output logic                      voted_led,
  output logic                      invalid,
  output logic [CNT_W-1:0]          result_out
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);

  state_t            state, next_state;
  logic [N_CAND-1:0] press;
  logic [3:0]        n_press;
  logic [N_CAND-1:0] sel_q, sel_d;
  logic [LW-1:0]     lock_cnt, cnt_d;
  logic              clr_q;
  logic [N_CAND-1:0] inc_d;
  logic              clr_d, ready_d, voted_d, inv_d;

  btn_edge_detect #(.W(N_CAND)) u_edge (
    .clk    (clk),
    .resetn (resetn),
    .btn    (cand_btn),
    .rise   (press)
  );

  assign n_press = popcnt8(8'(press));

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      sel_q       <= '0;
      lock_cnt    <= '0;
      clr_q       <= 1'b0;
      count_inc   <= '0;
      counter_clr <= 1'b0;
      ready_led   <= 1'b0;
      voted_led   <= 1'b0;
      invalid     <= 1'b0;
    end else begin
      state       <= next_state;
      sel_q       <= sel_d;
      lock_cnt    <= cnt_d;
      clr_q       <= clear_req;
      count_inc   <= inc_d;
      counter_clr <= clr_d;
      ready_led   <= ready_d;
      voted_led   <= voted_d;
      invalid     <= inv_d;
    end
  end

  // Next state and next output values.
  always_comb begin
    next_state = state;
    sel_d      = sel_q;
    cnt_d      = lock_cnt;
    inv_d      = 1'b0;
    unique case (state)
      IDLE: begin
        if (mode_result)    next_state = RESULT;
        else if (ballot_en) next_state = ARMED;
      end
      ARMED: begin
        unique case (1'b1)
          (n_press == 4'd1): begin
            next_state = CAST;
            sel_d      = press;
          end
          (n_press > 4'd1): inv_d = 1'b1;
          default: ;
        endcase
      end
      CAST: begin
        next_state = LOCK;
        cnt_d      = LW'(LOCK_CYCLES - 1);
      end
      LOCK: begin
        if (lock_cnt == '0) next_state = IDLE;
        else cnt_d = lock_cnt - 1'b1;
      end
      RESULT: begin
        if (!mode_result) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    inc_d   = (next_state == CAST) ? sel_d : '0;
    ready_d = (next_state == ARMED);
    voted_d = (next_state == LOCK);
    clr_d   = (state == RESULT) &&
              (next_state == RESULT) &&
              clear_req && !clr_q;
  end

  // Display mux; zero outside result mode.
  always_comb begin
    result_out = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (state == RESULT && int'(result_sel) == i)
        result_out = count_val[i*CNT_W +: CNT_W];
    end
  end

endmodule
